load_store_unit: RTL and testbench

Multi-cycle data-memory adapter between the hart's load/store datapath and a handshaked data memory. It sits directly downstream of the hart and replaces the single-cycle combinational dmem port. For each access it:
- generates byte-lane masks and aligns store data;
- sign/zero-extends load data;
- detects misaligned or illegal accesses;
- stalls the hart until the memory completes or a timeout expires.

---
 rtl/load_store_unit_if.sv | 41 ++++
 rtl/load_store_unit.sv | 182 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Bundle of hart-side and memory-side signals of the load/store unit.
// The LSU connects through the slave modport; whatever drives the hart
// request and models the data memory connects through the master modport.
interface load_store_unit_if;
  // Hart-side request
  logic        i_lsu_valid;
  logic        i_lsu_load;
  logic        i_lsu_store;
  logic [2:0]  i_lsu_funct3;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_lsu_wdata;
  // Hart-side response
  logic        o_lsu_busy;
  logic        o_lsu_done;
  logic [31:0] o_lsu_rdata;
  logic        o_lsu_trap;
  // Memory request
  logic [31:0] o_mem_addr;
  logic        o_mem_ren;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  // Memory response
  logic        i_mem_ready;
  logic        i_mem_valid;
  logic [31:0] i_mem_rdata;

  modport slave (
    input  i_lsu_valid, i_lsu_load, i_lsu_store, i_lsu_funct3, i_lsu_addr, i_lsu_wdata,
    output o_lsu_busy, o_lsu_done, o_lsu_rdata, o_lsu_trap,
    output o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_mem_mask,
    input  i_mem_ready, i_mem_valid, i_mem_rdata
  );

  modport master (
    output i_lsu_valid, i_lsu_load, i_lsu_store, i_lsu_funct3, i_lsu_addr, i_lsu_wdata,
    input  o_lsu_busy, o_lsu_done, o_lsu_rdata, o_lsu_trap,
    input  o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_mem_mask,
    output i_mem_ready, i_mem_valid, i_mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: captures a hart access, checks alignment and
// legality, drives a ready/valid data memory from registered state, extends
// load data and stalls the hart (busy) until completion or timeout.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  load_store_unit_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // The counter is cleared on entry to REQ, so the cycle in which it holds
  // TIMEOUT-2 is the last REQ/WAIT cycle; the next edge brings it to
  // TIMEOUT-1 and aborts the access.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 2);

  logic [1:0]  state_reg;
  logic [15:0] cnt_reg;
  logic        load_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  offset_reg;
  logic [31:0] rdata_reg;
  logic        trap_reg;
  logic [31:0] mem_addr_reg;
  logic        mem_ren_reg;
  logic        mem_wen_reg;
  logic [31:0] mem_wdata_reg;
  logic [3:0]  mem_mask_reg;

  logic        req_illegal;
  logic [3:0]  req_mask;
  logic [31:0] req_wdata;
  logic [3:0][1:0] lane_src;
  logic [31:0] load_shift;
  logic [31:0] load_ext;
  logic        cnt_expired;

  assign cnt_expired = (cnt_reg == CNT_LAST);

  // Decode legality and byte-lane mask of the request presented in IDLE.
  always_comb begin
    req_illegal = 1'b0;
    req_mask    = 4'b1111;
    if (bus.i_lsu_load == bus.i_lsu_store) begin
      req_illegal = 1'b1;
    end else if (bus.i_lsu_load &&
                 (bus.i_lsu_funct3 == 3'd3 || bus.i_lsu_funct3 == 3'd6 ||
                  bus.i_lsu_funct3 == 3'd7)) begin
      req_illegal = 1'b1;
    end else if (bus.i_lsu_store && bus.i_lsu_funct3 >= 3'd3) begin
      req_illegal = 1'b1;
    end else if (bus.i_lsu_funct3[1:0] == 2'd1 && bus.i_lsu_addr[0]) begin
      req_illegal = 1'b1;
    end else if (bus.i_lsu_funct3[1:0] == 2'd2 && bus.i_lsu_addr[1:0] != 2'd0) begin
      req_illegal = 1'b1;
    end
    case (bus.i_lsu_funct3[1:0])
      2'd0:    req_mask = 4'b0001 << bus.i_lsu_addr[1:0];
      2'd1:    req_mask = bus.i_lsu_addr[1] ? 4'b1100 : 4'b0011;
      default: req_mask = 4'b1111;
    endcase
  end

  // Each enabled lane takes the source byte (lane - offset); because the
  // access is naturally aligned this is the low byte/half/word shifted up.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_src[gi] = 2'(gi) - bus.i_lsu_addr[1:0];
    assign req_wdata[8*gi +: 8] = req_mask[gi] ? bus.i_lsu_wdata[8*lane_src[gi] +: 8] : 8'h00;
  end

  // Right-align the addressed bytes of the returned word and extend them.
  always_comb begin
    load_shift = bus.i_mem_rdata >> {offset_reg, 3'b000};
    case (funct3_reg)
      3'd0:    load_ext = {{24{load_shift[7]}}, load_shift[7:0]};
      3'd1:    load_ext = {{16{load_shift[15]}}, load_shift[15:0]};
      3'd2:    load_ext = load_shift;
      3'd4:    load_ext = {24'h0, load_shift[7:0]};
      3'd5:    load_ext = {16'h0, load_shift[15:0]};
      default: load_ext = 32'h0;
    endcase
  end

  // Access FSM, timeout counter and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 16'h0;
      load_reg      <= 1'b0;
      funct3_reg    <= 3'd0;
      offset_reg    <= 2'd0;
      rdata_reg     <= 32'h0;
      trap_reg      <= 1'b0;
      mem_addr_reg  <= 32'h0;
      mem_ren_reg   <= 1'b0;
      mem_wen_reg   <= 1'b0;
      mem_wdata_reg <= 32'h0;
      mem_mask_reg  <= 4'h0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.i_lsu_valid) begin
            if (req_illegal) begin
              // Trapped accesses never reach the memory.
              state_reg <= ST_DONE;
              trap_reg  <= 1'b1;
              rdata_reg <= 32'h0;
            end else begin
              state_reg     <= ST_REQ;
              cnt_reg       <= 16'h0;
              load_reg      <= bus.i_lsu_load;
              funct3_reg    <= bus.i_lsu_funct3;
              offset_reg    <= bus.i_lsu_addr[1:0];
              mem_addr_reg  <= {bus.i_lsu_addr[31:2], 2'b00};
              mem_mask_reg  <= req_mask;
              mem_wdata_reg <= req_wdata;
              mem_ren_reg   <= bus.i_lsu_load;
              mem_wen_reg   <= bus.i_lsu_store;
            end
          end
        end
        ST_REQ: begin
          cnt_reg <= cnt_reg + 16'd1;
          if (bus.i_mem_ready) begin
            mem_ren_reg <= 1'b0;
            mem_wen_reg <= 1'b0;
            if (!load_reg) begin
              state_reg <= ST_DONE;
            end else if (bus.i_mem_valid) begin
              state_reg <= ST_DONE;
              rdata_reg <= load_ext;
            end else if (cnt_expired) begin
              state_reg <= ST_DONE;
              trap_reg  <= 1'b1;
              rdata_reg <= 32'h0;
            end else begin
              state_reg <= ST_WAIT;
            end
          end else if (cnt_expired) begin
            state_reg   <= ST_DONE;
            trap_reg    <= 1'b1;
            rdata_reg   <= 32'h0;
            mem_ren_reg <= 1'b0;
            mem_wen_reg <= 1'b0;
          end
        end
        ST_WAIT: begin
          cnt_reg <= cnt_reg + 16'd1;
          if (bus.i_mem_valid) begin
            state_reg <= ST_DONE;
            rdata_reg <= load_ext;
          end else if (cnt_expired) begin
            state_reg <= ST_DONE;
            trap_reg  <= 1'b1;
            rdata_reg <= 32'h0;
          end
        end
        default: begin
          // DONE: single-cycle pulse; trap only qualifies that pulse.
          state_reg <= ST_IDLE;
          trap_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_lsu_busy  = (state_reg == ST_REQ) || (state_reg == ST_WAIT);
  assign bus.o_lsu_done  = (state_reg == ST_DONE);
  assign bus.o_lsu_rdata = rdata_reg;
  assign bus.o_lsu_trap  = trap_reg;
  assign bus.o_mem_addr  = mem_addr_reg;
  assign bus.o_mem_ren   = mem_ren_reg;
  assign bus.o_mem_wen   = mem_wen_reg;
  assign bus.o_mem_wdata = mem_wdata_reg;
  assign bus.o_mem_mask  = mem_mask_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: vector table replayed through a scoreboard,
// with a cycle-driven memory responder, plus reset and reset-mid-access cases.
module tb_load_store_unit;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit #(.TIMEOUT(TMO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic        load;
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          rc;          // cycle after accept in which ready is offered
    int          vc;          // cycle after accept in which valid is offered
    logic        exp_trap;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wdata;
    int          exp_done;    // cycle after accept in which done is seen
    int          exp_strobes; // cycles with ren or wen high
    int          exp_busy;    // cycles with busy high
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   n_vec = 0;
  int   n_checks = 0;
  int   n_mis = 0;

  function automatic vec_t mk(string name, logic ld, logic st, logic [2:0] f3,
                              logic [31:0] addr, logic [31:0] wdata, logic [31:0] mrdata,
                              int rc, int vc, logic trap, logic [31:0] rdata,
                              logic [3:0] mask, logic [31:0] wd, int dn, int strb, int busy);
    vec_t v;
    v.name = name; v.load = ld; v.store = st; v.f3 = f3; v.addr = addr;
    v.wdata = wdata; v.mrdata = mrdata; v.rc = rc; v.vc = vc; v.exp_trap = trap;
    v.exp_rdata = rdata; v.exp_mask = mask; v.exp_wdata = wd; v.exp_done = dn;
    v.exp_strobes = strb; v.exp_busy = busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_access(input vec_t v);
    vec_t        e;
    int          strobes = 0;
    int          busy = 0;
    int          done_c = 0;
    logic        got_done = 1'b0;
    logic        both_hi = 1'b0;
    logic        trap_seen = 1'b0;
    logic [31:0] rdata_seen = 32'h0;
    logic [3:0]  mask_seen = 4'h0;
    logic [31:0] addr_seen = 32'h0;
    logic [31:0] wdata_seen = 32'h0;
    @(negedge clk);
    bus.i_lsu_valid  = 1'b1;
    bus.i_lsu_load   = v.load;
    bus.i_lsu_store  = v.store;
    bus.i_lsu_funct3 = v.f3;
    bus.i_lsu_addr   = v.addr;
    bus.i_lsu_wdata  = v.wdata;
    bus.i_mem_rdata  = v.mrdata;
    bus.i_mem_ready  = 1'b0;
    bus.i_mem_valid  = 1'b0;
    sb_q.push_back(v);
    n_vec++;
    for (int c = 1; c <= 30 && !got_done; c++) begin
      @(negedge clk);
      bus.i_lsu_valid = 1'b0;
      if (bus.o_mem_ren && bus.o_mem_wen) both_hi = 1'b1;
      if (bus.o_lsu_busy) busy++;
      if (bus.o_mem_ren || bus.o_mem_wen) begin
        strobes++;
        mask_seen  = bus.o_mem_mask;
        addr_seen  = bus.o_mem_addr;
        wdata_seen = bus.o_mem_wdata;
      end
      if (bus.o_lsu_done) begin
        got_done   = 1'b1;
        done_c     = c;
        trap_seen  = bus.o_lsu_trap;
        rdata_seen = bus.o_lsu_rdata;
      end
      bus.i_mem_ready = !got_done && (c == v.rc);
      bus.i_mem_valid = !got_done && (c == v.vc);
    end
    bus.i_mem_ready = 1'b0;
    bus.i_mem_valid = 1'b0;
    e = sb_q.pop_front();
    if (!got_done) begin
      n_checks++;
      n_mis++;
      $display("FAIL %s no_done: got no done within 30 cycles, expected done at %0d", e.name, e.exp_done);
      return;
    end
    $display("txn %s: done@%0d trap=%0b rdata=%h strobes=%0d busy=%0d",
             e.name, done_c, trap_seen, rdata_seen, strobes, busy);
    check({e.name, " done_cycle"}, 32'(done_c), 32'(e.exp_done));
    check({e.name, " trap"}, 32'(trap_seen), 32'(e.exp_trap));
    if (e.load || e.exp_trap) check({e.name, " rdata"}, rdata_seen, e.exp_rdata);
    check({e.name, " strobe_cycles"}, 32'(strobes), 32'(e.exp_strobes));
    check({e.name, " busy_cycles"}, 32'(busy), 32'(e.exp_busy));
    check({e.name, " ren_wen_exclusive"}, 32'(both_hi), 32'd0);
    if (e.exp_strobes > 0) begin
      check({e.name, " mask"}, 32'(mask_seen), 32'(e.exp_mask));
      check({e.name, " mem_addr"}, addr_seen, {e.addr[31:2], 2'b00});
      if (e.store) check({e.name, " mem_wdata"}, wdata_seen, e.exp_wdata);
    end
  endtask

  initial begin
    //                 name        ld    st    f3    addr          wdata         mem rdata     rc vc trap  exp rdata     mask     exp wdata   dn st bz
    vecs.push_back(mk("lbu_1003",  1'b1, 1'b0, 3'd4, 32'h0000_1003, 32'h0,        32'h80FF_1234, 1, 1, 1'b0, 32'h0000_0080, 4'b1000, 32'h0,        2, 1, 1));
    vecs.push_back(mk("lh_2002",   1'b1, 1'b0, 3'd1, 32'h0000_2002, 32'h0,        32'h8001_0000, 1, 4, 1'b0, 32'hFFFF_8001, 4'b1100, 32'h0,        5, 1, 4));
    vecs.push_back(mk("sb_3001",   1'b0, 1'b1, 3'd0, 32'h0000_3001, 32'h1234_56AB, 32'h0,        3, 0, 1'b0, 32'h0,         4'b0010, 32'h0000_AB00, 4, 3, 3));
    vecs.push_back(mk("lw_mis",    1'b1, 1'b0, 3'd2, 32'h0000_4002, 32'h0,        32'hFFFF_FFFF, 1, 1, 1'b1, 32'h0,         4'b0000, 32'h0,        1, 0, 0));
    vecs.push_back(mk("lbu_1003b", 1'b1, 1'b0, 3'd4, 32'h0000_1003, 32'h0,        32'h80FF_1234, 1, 1, 1'b0, 32'h0000_0080, 4'b1000, 32'h0,        2, 1, 1));
    vecs.push_back(mk("ld_f3_3",   1'b1, 1'b0, 3'd3, 32'h0000_4000, 32'h0,        32'hFFFF_FFFF, 1, 1, 1'b1, 32'h0,         4'b0000, 32'h0,        1, 0, 0));
    vecs.push_back(mk("lw_tmo",    1'b1, 1'b0, 3'd2, 32'h0000_6000, 32'h0,        32'h1111_1111, 0, 0, 1'b1, 32'h0,         4'b1111, 32'h0,        8, 7, 7));
    vecs.push_back(mk("lb_7001",   1'b1, 1'b0, 3'd0, 32'h0000_7001, 32'h0,        32'h1234_F0AB, 1, 1, 1'b0, 32'hFFFF_FFF0, 4'b0010, 32'h0,        2, 1, 1));
    vecs.push_back(mk("lhu_7002",  1'b1, 1'b0, 3'd5, 32'h0000_7002, 32'h0,        32'h9ABC_0000, 2, 2, 1'b0, 32'h0000_9ABC, 4'b1100, 32'h0,        3, 2, 2));
    vecs.push_back(mk("lw_8000",   1'b1, 1'b0, 3'd2, 32'h0000_8000, 32'h0,        32'hDEAD_BEEF, 1, 2, 1'b0, 32'hDEAD_BEEF, 4'b1111, 32'h0,        3, 1, 2));
    vecs.push_back(mk("sw_9004",   1'b0, 1'b1, 3'd2, 32'h0000_9004, 32'hCAFE_F00D, 32'h0,        1, 0, 1'b0, 32'h0,         4'b1111, 32'hCAFE_F00D, 2, 1, 1));
    vecs.push_back(mk("sh_900A",   1'b0, 1'b1, 3'd1, 32'h0000_900A, 32'h1111_BEEF, 32'h0,        1, 0, 1'b0, 32'h0,         4'b1100, 32'hBEEF_0000, 2, 1, 1));
    vecs.push_back(mk("sh_mis",    1'b0, 1'b1, 3'd1, 32'h0000_9001, 32'h1111_BEEF, 32'h0,        1, 0, 1'b1, 32'h0,         4'b0000, 32'h0,        1, 0, 0));
    vecs.push_back(mk("ld_and_st", 1'b1, 1'b1, 3'd2, 32'h0000_9000, 32'h0,        32'h0,        1, 1, 1'b1, 32'h0,         4'b0000, 32'h0,        1, 0, 0));
    vecs.push_back(mk("no_type",   1'b0, 1'b0, 3'd2, 32'h0000_9000, 32'h0,        32'h0,        1, 1, 1'b1, 32'h0,         4'b0000, 32'h0,        1, 0, 0));
    vecs.push_back(mk("st_f3_4",   1'b0, 1'b1, 3'd4, 32'h0000_9000, 32'h5,        32'h0,        1, 0, 1'b1, 32'h0,         4'b0000, 32'h0,        1, 0, 0));
    vecs.push_back(mk("lb_B000",   1'b1, 1'b0, 3'd0, 32'h0000_B000, 32'h0,        32'h0000_007F, 1, 1, 1'b0, 32'h0000_007F, 4'b0001, 32'h0,        2, 1, 1));
    vecs.push_back(mk("lhu_wtmo",  1'b1, 1'b0, 3'd5, 32'h0000_B002, 32'h0,        32'h0,        1, 0, 1'b1, 32'h0,         4'b1100, 32'h0,        8, 1, 7));
    vecs.push_back(mk("sb_A003",   1'b0, 1'b1, 3'd0, 32'h0000_A003, 32'h0000_00C3, 32'h0,        1, 0, 1'b0, 32'h0,         4'b1000, 32'hC300_0000, 2, 1, 1));

    rst = 1'b1;
    bus.i_lsu_valid = 1'b0; bus.i_lsu_load = 1'b0; bus.i_lsu_store = 1'b0;
    bus.i_lsu_funct3 = 3'd0; bus.i_lsu_addr = 32'h0; bus.i_lsu_wdata = 32'h0;
    bus.i_mem_ready = 1'b0; bus.i_mem_valid = 1'b0; bus.i_mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check("reset busy",  32'(bus.o_lsu_busy), 32'd0);
    check("reset done",  32'(bus.o_lsu_done), 32'd0);
    check("reset trap",  32'(bus.o_lsu_trap), 32'd0);
    check("reset rdata", bus.o_lsu_rdata, 32'h0);
    check("reset ren",   32'(bus.o_mem_ren), 32'd0);
    check("reset wen",   32'(bus.o_mem_wen), 32'd0);
    check("reset mask",  32'(bus.o_mem_mask), 32'd0);
    check("reset addr",  bus.o_mem_addr, 32'h0);
    check("reset wdata", bus.o_mem_wdata, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_access(vecs[i]);

    // Reset while waiting for read data abandons the access.
    @(negedge clk);
    bus.i_lsu_valid = 1'b1; bus.i_lsu_load = 1'b1; bus.i_lsu_store = 1'b0;
    bus.i_lsu_funct3 = 3'd2; bus.i_lsu_addr = 32'h0000_C000;
    @(negedge clk);
    bus.i_lsu_valid = 1'b0;
    bus.i_mem_ready = 1'b1;
    @(negedge clk);
    bus.i_mem_ready = 1'b0;
    check("rst_wait busy_before", 32'(bus.o_lsu_busy), 32'd1);
    check("rst_wait ren_in_wait", 32'(bus.o_mem_ren), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("txn rst_in_wait: busy=%0b done=%0b ren=%0b wen=%0b", bus.o_lsu_busy,
             bus.o_lsu_done, bus.o_mem_ren, bus.o_mem_wen);
    check("rst_wait busy", 32'(bus.o_lsu_busy), 32'd0);
    check("rst_wait done", 32'(bus.o_lsu_done), 32'd0);
    check("rst_wait ren",  32'(bus.o_mem_ren), 32'd0);
    check("rst_wait wen",  32'(bus.o_mem_wen), 32'd0);
    check("rst_wait mask", 32'(bus.o_mem_mask), 32'd0);
    check("rst_wait addr", bus.o_mem_addr, 32'h0);
    check("rst_wait wdata", bus.o_mem_wdata, 32'h0);
    run_access(mk("lw_5000", 1'b1, 1'b0, 3'd2, 32'h0000_5000, 32'h0, 32'h1357_9BDF,
                  1, 1, 1'b0, 32'h1357_9BDF, 4'b1111, 32'h0, 2, 1, 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
